// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared bundle types, FSM states and decode constants for the memory stage
package mem_access_stage_pkg;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_e;

    typedef struct packed {
        logic [31:0] ALUResult;
        logic [31:0] RD2;
        logic [31:0] instr;
        logic [4:0]  A3;
        logic        RegW;
        logic        MemW;
        logic [1:0]  ResultSelect;
        logic [31:0] PC4;
    } Execute_Bundle;

    typedef struct packed {
        logic [31:0] Result;
        logic [4:0]  A3;
        logic        RegW;
        logic [1:0]  ResultSelect;
        logic [31:0] PC4;
        logic [31:0] instr;
        logic        misaligned;
        logic        bus_error;
    } Memory_Bundle;

    // Unsigned widths only exist for loads; undefined funct3 is reported as misaligned.
    function automatic logic access_ok(input logic [2:0] f3, input logic [1:0] addr_lo,
                                       input logic is_store);
        case (f3)
            F3_B:    access_ok = 1'b1;
            F3_H:    access_ok = ~addr_lo[0];
            F3_W:    access_ok = (addr_lo == 2'b00);
            F3_BU:   access_ok = ~is_store;
            F3_HU:   access_ok = ~is_store & ~addr_lo[0];
            default: access_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// rtl/mem_access_stage_load_align.sv - selects the addressed byte/halfword of a load word and extends it
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        case (i_funct3)
            F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_result = {24'b0, w_byte};
            F3_H:    o_result = {{16{w_half[15]}}, w_half};
            F3_HU:   o_result = {16'b0, w_half};
            default: o_result = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory stage: load/store over a valid/ready dmem port, registered Memory_Bundle out
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int RSP_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  Execute_Bundle EB,
    input  logic          in_valid,
    output logic          stall,
    output logic          dmem_req_valid,
    input  logic          dmem_req_ready,
    output logic [31:0]   dmem_addr,
    output logic          dmem_we,
    output logic [3:0]    dmem_be,
    output logic [31:0]   dmem_wdata,
    input  logic          dmem_rsp_valid,
    input  logic [31:0]   dmem_rdata,
    output Memory_Bundle  MB,
    output logic          out_valid
);

    localparam int CW = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(RSP_TIMEOUT - 1);

    mem_state_e   r_state;
    Memory_Bundle r_pend;
    Memory_Bundle r_mb;
    logic [CW-1:0] r_cnt;
    logic         r_stall;
    logic         r_req_valid;
    logic [31:0]  r_addr;
    logic         r_we;
    logic [3:0]   r_be;
    logic [31:0]  r_wdata;
    logic         r_out_valid;

    logic [2:0]   w_f3;
    logic         w_is_load;
    logic         w_is_store;
    logic         w_is_mem;
    logic         w_ok;
    logic [3:0]   w_be;
    logic [31:0]  w_wdata;
    logic [31:0]  w_load_result;
    Memory_Bundle w_eb_mb;

    assign w_f3       = EB.instr[14:12];
    assign w_is_load  = (EB.instr[6:0] == OPC_LOAD);
    assign w_is_store = EB.MemW;
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_ok       = access_ok(w_f3, EB.ALUResult[1:0], w_is_store);

    always_comb begin
        w_eb_mb = '{Result: EB.ALUResult, A3: EB.A3, RegW: EB.RegW,
                    ResultSelect: EB.ResultSelect, PC4: EB.PC4, instr: EB.instr,
                    misaligned: 1'b0, bus_error: 1'b0};
    end

    // Store data is replicated across every lane so the memory only has to honour byte enables.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = EB.RD2;
        if (w_is_store) begin
            case (w_f3)
                F3_B: begin
                    w_be    = 4'b0001 << EB.ALUResult[1:0];
                    w_wdata = {4{EB.RD2[7:0]}};
                end
                F3_H: begin
                    w_be    = EB.ALUResult[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{EB.RD2[15:0]}};
                end
                default: ;
            endcase
        end
    end

    mem_access_stage_load_align u_load_align (
        .i_rdata   (dmem_rdata),
        .i_addr_lo (r_pend.Result[1:0]),
        .i_funct3  (r_pend.instr[14:12]),
        .o_result  (w_load_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_pend      <= '0;
            r_mb        <= '0;
            r_cnt       <= '0;
            r_stall     <= 1'b0;
            r_req_valid <= 1'b0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_be        <= 4'b0000;
            r_wdata     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_pend <= w_eb_mb;
                        r_cnt  <= '0;
                        if (w_is_mem && w_ok) begin
                            r_state     <= REQ;
                            r_stall     <= 1'b1;
                            r_req_valid <= 1'b1;
                            r_addr      <= {EB.ALUResult[31:2], 2'b00};
                            r_we        <= w_is_store;
                            r_be        <= w_be;
                            r_wdata     <= w_wdata;
                        end else begin
                            r_mb            <= w_eb_mb;
                            r_mb.RegW       <= EB.RegW & ~w_is_mem;
                            r_mb.misaligned <= w_is_mem;
                            r_out_valid     <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // A response arriving alongside acceptance is ignored; only WAIT samples rsp_valid.
                    if (dmem_req_ready) begin
                        r_req_valid <= 1'b0;
                        if (r_we) begin
                            r_state     <= DONE;
                            r_stall     <= 1'b0;
                            r_mb        <= r_pend;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_rsp_valid) begin
                        r_state       <= DONE;
                        r_stall       <= 1'b0;
                        r_mb          <= r_pend;
                        r_mb.Result   <= w_load_result;
                        r_out_valid   <= 1'b1;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state      <= DONE;
                        r_stall      <= 1'b0;
                        r_mb         <= r_pend;
                        r_mb.Result  <= '0;
                        r_mb.RegW    <= 1'b0;
                        r_mb.bus_error <= 1'b1;
                        r_out_valid  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign stall          = r_stall;
    assign dmem_req_valid = r_req_valid;
    assign dmem_addr      = r_addr;
    assign dmem_we        = r_we;
    assign dmem_be        = r_be;
    assign dmem_wdata     = r_wdata;
    assign MB             = r_mb;
    assign out_valid      = r_out_valid;

endmodule
